// File: rtl/commit_tracker_pkg.sv
// Purpose : shared types and pointer helpers for the in-order commit tracker.
// Contents: ID_W/DEPTH constants, commit_id_t, ptr_t (ID plus wrap bit),
//           ptr_inc() and ptr_to_id() helpers.
`include "defines.svh"

package commit_tracker_pkg;

  localparam int ID_W  = `COMMIT_ID_WIDTH;
  localparam int DEPTH = 1 << ID_W;

  typedef logic [ID_W-1:0] commit_id_t;
  // Extra MSB distinguishes full from empty when head and tail IDs match.
  typedef logic [ID_W:0]   ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p, input logic [1:0] n);
    return p + ptr_t'(n);
  endfunction

  function automatic commit_id_t ptr_to_id(input ptr_t p);
    return p[ID_W-1:0];
  endfunction

endpackage

// File: rtl/defines.svh
`ifndef COMMIT_TRACKER_DEFINES_SVH
`define COMMIT_TRACKER_DEFINES_SVH

// Width of a commit ID; the tracker holds 2**COMMIT_ID_WIDTH entries.
`define COMMIT_ID_WIDTH 3

`endif

// File: rtl/commit_tracker.sv
// Purpose : allocates sequential commit IDs (2/cycle), marks them done from the
//           writeback unit out of order, and retires done entries in order (2/cycle).
// Ports   : clk/rst (sync, active-high); alloc*_req_i/alloc_gnt_o/alloc*_id_o to
//           dispatch; commit_valid*/commit_id* from WBU; flush_i; retire_* out;
//           count_o/full_o/empty_o occupancy; err_o sticky protocol error.
module commit_tracker
  import commit_tracker_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc1_req_i,
  input  logic            alloc2_req_i,
  output logic            alloc_gnt_o,
  output logic [ID_W-1:0] alloc1_id_o,
  output logic [ID_W-1:0] alloc2_id_o,
  input  logic            commit_valid1_i,
  input  logic [ID_W-1:0] commit_id1_i,
  input  logic            commit_valid2_i,
  input  logic [ID_W-1:0] commit_id2_i,
  input  logic            flush_i,
  output logic            retire_valid1_o,
  output logic [ID_W-1:0] retire_id1_o,
  output logic            retire_valid2_o,
  output logic [ID_W-1:0] retire_id2_o,
  output logic [ID_W:0]   count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            err_o
);

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  ptr_t             r_head;
  ptr_t             r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic             r_err;

  ptr_t             w_count;
  ptr_t             w_free;
  logic [1:0]       w_n_req;
  logic [1:0]       w_n_ret;
  commit_id_t       w_head_id;
  commit_id_t       w_head1_id;
  commit_id_t       w_tail_id;
  commit_id_t       w_tail1_id;
  logic             w_dup;
  logic             w_c1_ok;
  logic             w_c2_ok;
  logic             w_err_evt;

  ptr_t             w_head_nxt;
  ptr_t             w_tail_nxt;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [DEPTH-1:0] w_done_nxt;

  // Occupancy and free space are both taken from start-of-cycle pointers, so
  // retirements in this cycle never make room for an allocation in this cycle.
  assign w_count = r_tail - r_head;
  assign w_free  = DEPTH_P - w_count;
  assign w_n_req = {1'b0, alloc1_req_i} + {1'b0, alloc1_req_i & alloc2_req_i};

  assign w_head_id  = ptr_to_id(r_head);
  assign w_head1_id = ptr_to_id(ptr_inc(r_head, 2'd1));
  assign w_tail_id  = ptr_to_id(r_tail);
  assign w_tail1_id = ptr_to_id(ptr_inc(r_tail, 2'd1));

  // All-or-nothing grant: a dual request with a single free entry gets nothing.
  assign alloc_gnt_o = (w_n_req != 2'd0) && (w_free >= ptr_t'(w_n_req)) && !flush_i;
  assign alloc1_id_o = w_tail_id;
  assign alloc2_id_o = w_tail1_id;

  assign retire_valid1_o = r_valid[w_head_id] & r_done[w_head_id] & !flush_i;
  assign retire_valid2_o = retire_valid1_o & r_valid[w_head1_id] & r_done[w_head1_id];
  assign retire_id1_o    = w_head_id;
  assign retire_id2_o    = w_head1_id;
  assign w_n_ret         = {1'b0, retire_valid1_o} + {1'b0, retire_valid2_o};

  // A commit is legal only to an in-flight, not-yet-done entry, and the two
  // channels must name different IDs. Illegal commits only raise err.
  assign w_dup     = commit_valid1_i & commit_valid2_i & (commit_id1_i == commit_id2_i);
  assign w_c1_ok   = commit_valid1_i & r_valid[commit_id1_i] & !r_done[commit_id1_i] & !w_dup;
  assign w_c2_ok   = commit_valid2_i & r_valid[commit_id2_i] & !r_done[commit_id2_i] & !w_dup;
  assign w_err_evt = (commit_valid1_i & !w_c1_ok) | (commit_valid2_i & !w_c2_ok);

  assign count_o = w_count;
  assign full_o  = (w_count == DEPTH_P);
  assign empty_o = (w_count == '0);
  assign err_o   = r_err;

  // Retired, allocated and committed entries are always disjoint sets: a
  // retiring entry is already done (commit to it is illegal), and an entry
  // being allocated was invalid (commit to it is illegal), so update order
  // below does not matter.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    if (flush_i) begin
      w_valid_nxt = '0;
      w_done_nxt  = '0;
      w_tail_nxt  = r_head;
    end else begin
      if (retire_valid1_o) begin
        w_valid_nxt[w_head_id] = 1'b0;
        w_done_nxt[w_head_id]  = 1'b0;
      end
      if (retire_valid2_o) begin
        w_valid_nxt[w_head1_id] = 1'b0;
        w_done_nxt[w_head1_id]  = 1'b0;
      end
      w_head_nxt = ptr_inc(r_head, w_n_ret);

      if (alloc_gnt_o) begin
        w_valid_nxt[w_tail_id] = 1'b1;
        w_done_nxt[w_tail_id]  = 1'b0;
        if (w_n_req == 2'd2) begin
          w_valid_nxt[w_tail1_id] = 1'b1;
          w_done_nxt[w_tail1_id]  = 1'b0;
        end
        w_tail_nxt = ptr_inc(r_tail, w_n_req);
      end

      if (w_c1_ok) w_done_nxt[commit_id1_i] = 1'b1;
      if (w_c2_ok) w_done_nxt[commit_id2_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      // Sticky until reset; flush leaves it alone.
      if (w_err_evt) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_tracker.sv
// Purpose : directed self-checking bench for commit_tracker.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit after the inputs settle, well away from the active edge.
module tb_commit_tracker;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc1_req_i, alloc2_req_i;
  logic         alloc_gnt_o;
  logic [W-1:0] alloc1_id_o, alloc2_id_o;
  logic         commit_valid1_i, commit_valid2_i;
  logic [W-1:0] commit_id1_i, commit_id2_i;
  logic         flush_i;
  logic         retire_valid1_o, retire_valid2_o;
  logic [W-1:0] retire_id1_o, retire_id2_o;
  logic [W:0]   count_o;
  logic         full_o, empty_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  commit_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .alloc1_req_i    (alloc1_req_i),
    .alloc2_req_i    (alloc2_req_i),
    .alloc_gnt_o     (alloc_gnt_o),
    .alloc1_id_o     (alloc1_id_o),
    .alloc2_id_o     (alloc2_id_o),
    .commit_valid1_i (commit_valid1_i),
    .commit_id1_i    (commit_id1_i),
    .commit_valid2_i (commit_valid2_i),
    .commit_id2_i    (commit_id2_i),
    .flush_i         (flush_i),
    .retire_valid1_o (retire_valid1_o),
    .retire_id1_o    (retire_id1_o),
    .retire_valid2_o (retire_valid2_o),
    .retire_id2_o    (retire_id2_o),
    .count_o         (count_o),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    alloc1_req_i = 1'b0; alloc2_req_i = 1'b0;
    commit_valid1_i = 1'b0; commit_id1_i = '0;
    commit_valid2_i = 1'b0; commit_id2_i = '0;
    flush_i = 1'b0;
  endtask

  // Advance one clock: land 1 unit past the edge and drop all requests.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic two);
    alloc1_req_i = 1'b1;
    alloc2_req_i = two;
    tick();
  endtask

  task automatic commit(input logic v1, input logic [W-1:0] id1,
                        input logic v2, input logic [W-1:0] id2);
    commit_valid1_i = v1; commit_id1_i = id1;
    commit_valid2_i = v2; commit_id2_i = id2;
    tick();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #1;
    do_reset();

    // 1: reset state, then a dual allocation
    settle();
    check("rst_count",  32'(count_o), 32'd0);
    check("rst_empty",  32'(empty_o), 32'd1);
    check("rst_full",   32'(full_o), 32'd0);
    check("rst_rv1",    32'(retire_valid1_o), 32'd0);
    check("rst_rv2",    32'(retire_valid2_o), 32'd0);
    check("rst_err",    32'(err_o), 32'd0);
    check("rst_aid1",   32'(alloc1_id_o), 32'd0);
    check("rst_aid2",   32'(alloc2_id_o), 32'd1);
    alloc1_req_i = 1'b1; alloc2_req_i = 1'b1;
    settle();
    check("t1_gnt",  32'(alloc_gnt_o), 32'd1);
    check("t1_id1",  32'(alloc1_id_o), 32'd0);
    check("t1_id2",  32'(alloc2_id_o), 32'd1);
    tick();
    settle();
    check("t1_count", 32'(count_o), 32'd2);
    check("t1_empty", 32'(empty_o), 32'd0);

    // 2: out-of-order completion, in-order retirement
    do_reset();
    alloc(1'b1);
    alloc(1'b0);
    settle();
    check("t2_count3", 32'(count_o), 32'd3);
    commit(1'b1, 3'd2, 1'b0, 3'd0);
    commit_valid1_i = 1'b1; commit_id1_i = 3'd0;
    settle();
    check("t2_head_same_cyc", 32'(retire_valid1_o), 32'd0);
    tick();
    commit_valid1_i = 1'b1; commit_id1_i = 3'd1;
    settle();
    check("t2_rv1",  32'(retire_valid1_o), 32'd1);
    check("t2_rid1", 32'(retire_id1_o), 32'd0);
    check("t2_rv2",  32'(retire_valid2_o), 32'd0);
    tick();
    settle();
    check("t2_rv1b",  32'(retire_valid1_o), 32'd1);
    check("t2_rid1b", 32'(retire_id1_o), 32'd1);
    check("t2_rv2b",  32'(retire_valid2_o), 32'd1);
    check("t2_rid2b", 32'(retire_id2_o), 32'd2);
    tick();
    settle();
    check("t2_count0", 32'(count_o), 32'd0);
    check("t2_empty",  32'(empty_o), 32'd1);

    // 3: full, all-or-nothing grant, retirements not credited same cycle
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b1);
    settle();
    check("t3_full",  32'(full_o), 32'd1);
    check("t3_count", 32'(count_o), 32'd8);
    alloc1_req_i = 1'b1;
    settle();
    check("t3_gnt_full", 32'(alloc_gnt_o), 32'd0);
    clr();
    commit(1'b1, 3'd0, 1'b0, 3'd0);
    alloc1_req_i = 1'b1; alloc2_req_i = 1'b1;
    settle();
    check("t3_rv_full", 32'(retire_valid1_o), 32'd1);
    check("t3_gnt_noc", 32'(alloc_gnt_o), 32'd0);
    tick();
    settle();
    check("t3_count7", 32'(count_o), 32'd7);
    alloc1_req_i = 1'b1; alloc2_req_i = 1'b1;
    settle();
    check("t3_gnt_dual1", 32'(alloc_gnt_o), 32'd0);
    alloc2_req_i = 1'b0;
    settle();
    check("t3_gnt_single", 32'(alloc_gnt_o), 32'd1);
    check("t3_id_wrap",    32'(alloc1_id_o), 32'd0);
    tick();
    settle();
    check("t3_full_again", 32'(full_o), 32'd1);

    // 4: wrap-around of IDs
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc(1'b0);
      commit(1'b1, 3'(i), 1'b0, 3'd0);
      settle();
      check("t4_walk_rid", 32'(retire_id1_o), 32'(i));
      tick();
    end
    settle();
    check("t4_empty", 32'(empty_o), 32'd1);
    alloc1_req_i = 1'b1; alloc2_req_i = 1'b1;
    settle();
    check("t4_id1", 32'(alloc1_id_o), 32'd7);
    check("t4_id2", 32'(alloc2_id_o), 32'd0);
    tick();
    commit(1'b1, 3'd0, 1'b1, 3'd7);
    settle();
    check("t4_rv1",  32'(retire_valid1_o), 32'd1);
    check("t4_rid1", 32'(retire_id1_o), 32'd7);
    check("t4_rv2",  32'(retire_valid2_o), 32'd1);
    check("t4_rid2", 32'(retire_id2_o), 32'd0);
    tick();
    settle();
    check("t4_empty2", 32'(empty_o), 32'd1);

    // 5: flush suppresses retire/grant and rewinds tail to head
    do_reset();
    alloc(1'b1);
    alloc(1'b0);
    commit(1'b1, 3'd0, 1'b0, 3'd0);
    flush_i = 1'b1; alloc1_req_i = 1'b1;
    settle();
    check("t5_rv_flush",  32'(retire_valid1_o), 32'd0);
    check("t5_gnt_flush", 32'(alloc_gnt_o), 32'd0);
    tick();
    settle();
    check("t5_count", 32'(count_o), 32'd0);
    check("t5_empty", 32'(empty_o), 32'd1);
    alloc1_req_i = 1'b1;
    settle();
    check("t5_gnt", 32'(alloc_gnt_o), 32'd1);
    check("t5_id",  32'(alloc1_id_o), 32'd0);
    tick();

    // 6: protocol errors
    do_reset();
    alloc(1'b1);
    alloc(1'b1);
    settle();
    check("t6_err0", 32'(err_o), 32'd0);
    commit(1'b1, 3'd5, 1'b0, 3'd0);
    settle();
    check("t6_err_unalloc", 32'(err_o), 32'd1);
    check("t6_count", 32'(count_o), 32'd4);
    flush_i = 1'b1;
    tick();
    settle();
    check("t6_err_flush", 32'(err_o), 32'd1);

    do_reset();
    settle();
    check("t6_err_rst", 32'(err_o), 32'd0);
    alloc(1'b1);
    alloc(1'b1);
    commit(1'b1, 3'd3, 1'b1, 3'd3);
    settle();
    check("t6_err_dup", 32'(err_o), 32'd1);
    commit(1'b1, 3'd0, 1'b1, 3'd1);
    commit_valid1_i = 1'b1; commit_id1_i = 3'd2;
    settle();
    check("t6_rv2_01", 32'(retire_valid2_o), 32'd1);
    tick();
    settle();
    check("t6_rid1_2", 32'(retire_id1_o), 32'd2);
    check("t6_rv1_2",  32'(retire_valid1_o), 32'd1);
    check("t6_dup_noeffect", 32'(retire_valid2_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
